// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM state type for the fixed-latency line memory responder.
package dmem_responder_pkg;

  localparam int unsigned LINE_W   = 256;  // bits per stored line
  localparam int unsigned OFFSET_W = 5;    // byte offset bits inside a line
  localparam int unsigned ADDR_W   = 32;   // initiator byte address width
  localparam int unsigned CNT_W    = 8;    // latency counter width, covers 2..255

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: DEPTH lines of LINE_W bits, synchronous write, combinational read.
module dmem_line_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Store one line on a write strobe.
  // NOTE: the array has no reset; contents survive rst_i and are loaded externally.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read port is asynchronous so the controller can latch data on the completing edge.
  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line memory responder: accepts one request, waits LATENCY cycles,
// performs the access and pulses ack_o. data_o and ack_o come straight from flops.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              req_write_q, req_write_d;
  logic [IDX_W-1:0]  req_idx_q,   req_idx_d;
  logic [LINE_W-1:0] req_data_q,  req_data_d;
  logic              ack_q,       ack_d;
  logic [LINE_W-1:0] rdata_q,     rdata_d;

  logic              mem_we;
  logic [LINE_W-1:0] mem_rdata;

  // Byte offset and bits above the line index intentionally select nothing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // Next-state logic: accept in IDLE, count down in BUSY, access on the BUSY->ACK step.
  // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_write_d = req_write_q;
    req_idx_d   = req_idx_q;
    req_data_d  = req_data_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          req_write_d = write_i;
          req_idx_d   = addr_i[OFFSET_W +: IDX_W];
          req_data_d  = data_i;
          cnt_d       = CNT_LOAD;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = ST_ACK;
          if (req_write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ACK: begin
        // The ack flop rises on the edge leaving ACK, so IDLE can accept while ack_o is high.
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, request and output registers; everything clears on reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_write_q <= req_write_d;
      req_idx_q   <= req_idx_d;
      req_data_q  <= req_data_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (req_idx_q),
    .wdata_i (req_data_q),
    .raddr_i (req_idx_q),
    .rdata_o (mem_rdata)
  );

  assign ack_o  = ack_q;
  assign data_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal expectations
// plus randomized transactions compared every cycle against a behavioural model.
module tb_dmem_responder;

  localparam int unsigned LATENCY = 10;
  localparam int unsigned DEPTH   = 512;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         ack_o;
  logic [255:0] data_o;

  dmem_responder #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] preload_line(input int unsigned i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | i;
    return {8{w}};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  logic [255:0] model_mem [DEPTH];
  int           cyc = 0;
  int           free_at = 0;
  bit           pend = 0;
  int           pend_done;
  bit           pend_w;
  int unsigned  pend_idx;
  logic [255:0] pend_data;
  bit           exp_ack = 0;
  logic [255:0] exp_data = '0;

  // A request seen at an idle edge completes LATENCY edges later; the responder can
  // take the next request one edge after that completion. Reset drops anything pending.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend     = 0;
      exp_ack  = 0;
      exp_data = '0;
      free_at  = 0;
    end else begin
      cyc++;
      exp_ack = 0;
      if (pend && cyc == pend_done) begin
        exp_ack = 1;
        pend    = 0;
        free_at = cyc + 1;
        if (pend_w) model_mem[pend_idx] = pend_data;
        else        exp_data = model_mem[pend_idx];
      end else if (!pend && cyc >= free_at && enable_i) begin
        pend      = 1;
        pend_done = cyc + LATENCY;
        pend_w    = write_i;
        pend_idx  = (addr_i >> 5) % DEPTH;
        pend_data = data_i;
      end
    end
  end

  // Per-cycle comparison of the outputs against the model.
  always @(negedge clk_i) begin
    if (checking && rst_i) begin
      check("ack_o", {255'd0, ack_o}, {255'd0, exp_ack});
      if (exp_ack) check("data_o_at_ack", data_o, exp_data);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic wait_ack(output int t, output logic [255:0] d);
    t = -1;
    d = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        t = cyc;
        d = data_o;
        break;
      end
    end
    if (t < 0) check("ack_timeout", 256'd0, 256'd1);
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [255:0] d,
                     input int hold, output int lat, output logic [255:0] dout);
    int t0, t1;
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    @(negedge clk_i);
    t0 = cyc;
    repeat (hold) @(negedge clk_i);
    enable_i = 1'b0;
    write_i  = 1'($urandom);
    wait_ack(t1, dout);
    lat = (t1 < 0) ? -1 : t1 - t0;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int           lat, t0, t1, t2, acks;
    logic [255:0] d, d1, d2, a5_line;
    logic [31:0]  ra;

    a5_line = {32{8'hA5}};
    for (int i = 0; i < DEPTH; i++) begin
      dut.u_array.mem[i] = preload_line(i);
      model_mem[i]       = preload_line(i);
    end

    repeat (3) @(negedge clk_i);
    check("reset_ack", {255'd0, ack_o}, 256'd0);
    check("reset_data", data_o, 256'd0);

    // Release reset and present the first request immediately.
    rst_i    = 1'b1;
    checking = 1'b1;
    txn(1'b1, 32'h0000_0040, a5_line, 0, lat, d);
    check("wr_latency", lat, 10);
    check("wr_leaves_data_o", d, 256'd0);
    @(negedge clk_i);
    check("ack_one_cycle", {255'd0, ack_o}, 256'd0);

    txn(1'b0, 32'h0000_0040, '0, 0, lat, d);
    check("rd_latency", lat, 10);
    check("rd_after_wr", d, a5_line);
    txn(1'b0, 32'h0000_4040, '0, 0, lat, d);
    check("rd_alias", d, a5_line);
    txn(1'b0, 32'h0000_005F, '0, 0, lat, d);
    check("rd_offset_bits", d, a5_line);

    // Back-to-back reads with enable held high throughout.
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h0000_0100;
    @(negedge clk_i);
    t0 = cyc;
    wait_ack(t1, d1);
    addr_i = 32'h0000_0200;
    wait_ack(t2, d2);
    enable_i = 1'b0;
    check("b2b_first_latency", t1 - t0, 10);
    check("b2b_first_data", d1, {8{32'hC0DE_0008}});
    check("b2b_gap", t2 - t1, 11);
    check("b2b_second_data", d2, {8{32'hC0DE_0010}});
    @(negedge clk_i);
    check("b2b_no_repeat", {255'd0, ack_o}, 256'd0);

    // Reset in the middle of a write aborts it.
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0080;
    data_i   = rand_line();
    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midreset_ack", {255'd0, ack_o}, 256'd0);
    check("midreset_data", data_o, 256'd0);
    rst_i = 1'b1;
    acks = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check("abort_no_ack", acks, 0);
    txn(1'b0, 32'h0000_0080, '0, 0, lat, d);
    check("abort_no_write", d, {8{32'hC0DE_0004}});

    // Enable dropped two cycles into BUSY still completes on time.
    txn(1'b0, 32'h0000_0040, '0, 2, lat, d);
    check("drop_en_latency", lat, 10);
    check("drop_en_data", d, a5_line);

    // Randomized traffic over a few lines, with random alias/offset bits and gaps.
    for (int n = 0; n < 40; n++) begin
      ra       = $urandom;
      ra[13:5] = 9'($urandom_range(0, 7));
      txn(1'($urandom), ra, rand_line(), $urandom_range(0, 3), lat, d);
      check("rnd_latency", lat, LATENCY);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
